// File: rtl/multi_channel_scoreboard.sv
// multi_channel_scoreboard
// Tracks CHANNELS independent FIFO-like channels beside a DUT. On a start-qualified
// push, each channel captures one tagged word and counts how many words are queued
// ahead of it. When that word reaches the head, it is compared against data_out.
// Overflow and underflow are also flagged. prop_signal stays high while no channel
// has failed.
// Optional feature: define SB_LATENCY_EN to add the max_latency output, which holds
// the largest capture-to-check cycle count seen on any channel.
module multi_channel_scoreboard #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int CHANNELS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CHANNELS-1:0]       push,
  input  logic [CHANNELS-1:0]       pop,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS*WIDTH-1:0] data_out,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS-1:0]       chan_fail,
`ifdef SB_LATENCY_EN
  output logic [15:0]               max_latency,
`endif
  output logic                      prop_signal
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_ZERO  = {OCC_W{1'b0}};
  localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_DEPTH = OCC_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

`ifdef SB_LATENCY_EN
  logic [CHANNELS-1:0]    lat_done_s;
  logic [CHANNELS*16-1:0] lat_val_s;
  logic                   lat_any_s;
  logic [15:0]            lat_cand_s;
  logic [15:0]            max_latency_r;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    state_t           state_r;
    logic [OCC_W-1:0] occ_r;
    logic [OCC_W-1:0] occ_nxt_s;
    logic [OCC_W-1:0] ahead_r;
    logic [OCC_W-1:0] ahead_arm_s;
    logic [WIDTH-1:0] tag_r;
    logic [WIDTH-1:0] din_s;
    logic [WIDTH-1:0] dout_s;
    logic             push_s;
    logic             pop_s;
    logic             ovf_s;
    logic             udf_s;
    logic             arm_s;
    logic             check_s;
    logic             miss_s;
    logic             done_r;
    logic             fail_r;

    assign push_s  = push[c];
    assign pop_s   = pop[c];
    assign din_s   = data_in[c*WIDTH +: WIDTH];
    assign dout_s  = data_out[c*WIDTH +: WIDTH];
    assign ovf_s   = push_s && !pop_s && (occ_r == OCC_DEPTH);
    assign udf_s   = pop_s && (occ_r == OCC_ZERO);
    assign arm_s   = (state_r == ST_IDLE) && start && push_s;
    assign check_s = (state_r == ST_TRACK) && pop_s && (ahead_r == OCC_ZERO);
    assign miss_s  = check_s && (dout_s != tag_r);

    // Words ahead of the tagged word: current occupancy minus a head word leaving now.
    assign ahead_arm_s = (pop_s && (occ_r != OCC_ZERO)) ? (occ_r - OCC_ONE) : occ_r;

    // Next occupancy: saturate on overflow, hold at zero on underflow.
    always_comb begin
      occ_nxt_s = occ_r;
      if (push_s && !pop_s) begin
        if (occ_r == OCC_DEPTH) begin
          occ_nxt_s = occ_r;
        end else begin
          occ_nxt_s = occ_r + OCC_ONE;
        end
      end else if (pop_s && !push_s) begin
        if (occ_r == OCC_ZERO) begin
          occ_nxt_s = occ_r;
        end else begin
          occ_nxt_s = occ_r - OCC_ONE;
        end
      end else if (push_s && pop_s) begin
        if (occ_r == OCC_ZERO) begin
          occ_nxt_s = OCC_ONE;
        end else begin
          occ_nxt_s = occ_r;
        end
      end else begin
        occ_nxt_s = occ_r;
      end
    end

    // Per-channel tracking FSM, occupancy and sticky failure flag.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_r <= ST_IDLE;
        occ_r   <= OCC_ZERO;
        ahead_r <= OCC_ZERO;
        tag_r   <= {WIDTH{1'b0}};
        done_r  <= 1'b0;
        fail_r  <= 1'b0;
      end else begin
        occ_r <= occ_nxt_s;
        if (ovf_s || udf_s || miss_s) begin
          fail_r <= 1'b1;
        end
        case (state_r)
          ST_IDLE: begin
            if (arm_s) begin
              state_r <= ST_TRACK;
              tag_r   <= din_s;
              ahead_r <= ahead_arm_s;
            end
          end
          ST_TRACK: begin
            if (pop_s) begin
              if (ahead_r == OCC_ZERO) begin
                state_r <= ST_DONE;
                done_r  <= 1'b1;
              end else begin
                ahead_r <= ahead_r - OCC_ONE;
              end
            end
          end
          ST_DONE: begin
            done_r <= 1'b1;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end

    assign done[c]      = done_r;
    assign chan_fail[c] = fail_r;

`ifdef SB_LATENCY_EN
    logic [15:0] lat_r;
    logic [15:0] lat_inc_s;

    assign lat_inc_s = (lat_r == 16'hFFFF) ? lat_r : (lat_r + 16'd1);

    // Capture-to-check cycle counter: cleared on capture, counts while tracking.
    always_ff @(posedge clk) begin
      if (rst) begin
        lat_r <= 16'd0;
      end else if (arm_s) begin
        lat_r <= 16'd0;
      end else if (state_r == ST_TRACK) begin
        lat_r <= lat_inc_s;
      end
    end

    assign lat_done_s[c]           = check_s;
    assign lat_val_s[c*16 +: 16]   = lat_inc_s;
`endif
  end

  assign prop_signal = ~|chan_fail;

`ifdef SB_LATENCY_EN
  // Largest latency among the channels completing their check this cycle.
  always_comb begin
    lat_any_s  = 1'b0;
    lat_cand_s = 16'd0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (lat_done_s[i]) begin
        lat_any_s = 1'b1;
        if (lat_val_s[i*16 +: 16] > lat_cand_s) begin
          lat_cand_s = lat_val_s[i*16 +: 16];
        end else begin
          lat_cand_s = lat_cand_s;
        end
      end else begin
        lat_cand_s = lat_cand_s;
      end
    end
  end

  // Running maximum, updated on the same edge that raises done.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_latency_r <= 16'd0;
    end else if (lat_any_s && (lat_cand_s > max_latency_r)) begin
      max_latency_r <= lat_cand_s;
    end
  end

  assign max_latency = max_latency_r;
`endif

endmodule

// File: tb/tb_multi_channel_scoreboard.sv
// Directed self-checking bench for multi_channel_scoreboard (WIDTH=8, DEPTH=4, CHANNELS=2).
module tb_multi_channel_scoreboard;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  push;
  logic [1:0]  pop;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic [1:0]  done;
  logic [1:0]  chan_fail;
  logic        prop_signal;
`ifdef SB_LATENCY_EN
  logic [15:0] max_latency;
`endif

  int checks   = 0;
  int failures = 0;

  multi_channel_scoreboard #(.WIDTH(8), .DEPTH(4), .CHANNELS(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .push        (push),
    .pop         (pop),
    .data_in     (data_in),
    .data_out    (data_out),
    .done        (done),
    .chan_fail   (chan_fail),
`ifdef SB_LATENCY_EN
    .max_latency (max_latency),
`endif
    .prop_signal (prop_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given strobes; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic s, input logic [1:0] pu, input logic [1:0] po,
                     input logic [7:0] di0, input logic [7:0] di1,
                     input logic [7:0] do0, input logic [7:0] do1);
    start    = s;
    push     = pu;
    pop      = po;
    data_in  = {di1, di0};
    data_out = {do1, do0};
    @(posedge clk);
    #1;
    start    = 1'b0;
    push     = 2'b00;
    pop      = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    cyc(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; push = 2'b00; pop = 2'b00;
    data_in = 16'h0000; data_out = 16'h0000;
    #2;

    // Reset, then idle
    do_reset();
    check("rst_prop", {31'd0, prop_signal}, 32'd1);
    check("rst_done", {30'd0, done}, 32'd0);
    check("rst_fail", {30'd0, chan_fail}, 32'd0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    check("idle_prop", {31'd0, prop_signal}, 32'd1);
    check("idle_done", {30'd0, done}, 32'd0);
    check("idle_fail", {30'd0, chan_fail}, 32'd0);
`ifdef SB_LATENCY_EN
    check("rst_maxlat", {16'd0, max_latency}, 32'd0);
`endif

    // Ch0 in-order match: two words ahead of the tag
    cyc(1'b0, 2'b01, 2'b00, 8'h11, 8'h00, 8'h00, 8'h00);
    cyc(1'b0, 2'b01, 2'b00, 8'h22, 8'h00, 8'h00, 8'h00);
    cyc(1'b1, 2'b01, 2'b00, 8'hA5, 8'h00, 8'h00, 8'h00);
    cyc(1'b0, 2'b00, 2'b01, 8'h00, 8'h00, 8'h11, 8'h00);
    cyc(1'b0, 2'b00, 2'b01, 8'h00, 8'h00, 8'h22, 8'h00);
    check("match_done_early", {30'd0, done}, 32'd0);
    cyc(1'b0, 2'b00, 2'b01, 8'h00, 8'h00, 8'hA5, 8'h00);
    check("match_done", {30'd0, done}, 32'd1);
    check("match_prop", {31'd0, prop_signal}, 32'd1);
    check("match_fail", {30'd0, chan_fail}, 32'd0);

    // Ch0 data mismatch on the tagged word
    do_reset();
    check("reset_clears_done", {30'd0, done}, 32'd0);
    cyc(1'b0, 2'b01, 2'b00, 8'h11, 8'h00, 8'h00, 8'h00);
    cyc(1'b0, 2'b01, 2'b00, 8'h22, 8'h00, 8'h00, 8'h00);
    cyc(1'b1, 2'b01, 2'b00, 8'hA5, 8'h00, 8'h00, 8'h00);
    cyc(1'b0, 2'b00, 2'b01, 8'h00, 8'h00, 8'h11, 8'h00);
    cyc(1'b0, 2'b00, 2'b01, 8'h00, 8'h00, 8'h22, 8'h00);
    check("mis_prop_before", {31'd0, prop_signal}, 32'd1);
    cyc(1'b0, 2'b00, 2'b01, 8'h00, 8'h00, 8'h5A, 8'h00);
    check("mis_fail", {30'd0, chan_fail}, 32'd1);
    check("mis_prop", {31'd0, prop_signal}, 32'd0);
    cyc(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    check("mis_sticky", {30'd0, chan_fail}, 32'd1);

    // Ch1 overflow on the fifth push
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 2'b10, 2'b00, 8'h00, 8'(i), 8'h00, 8'h00);
    check("ovf_before", {30'd0, chan_fail}, 32'd0);
    cyc(1'b0, 2'b10, 2'b00, 8'h00, 8'h44, 8'h00, 8'h00);
    check("ovf_fail", {30'd0, chan_fail}, 32'd2);
    check("ovf_prop", {31'd0, prop_signal}, 32'd0);

    // Ch1 underflow right after reset
    do_reset();
    check("udf_clear", {30'd0, chan_fail}, 32'd0);
    cyc(1'b0, 2'b00, 2'b10, 8'h00, 8'h00, 8'h00, 8'h00);
    check("udf_fail", {30'd0, chan_fail}, 32'd2);

    // Both channels arm together with push+pop at occupancy 2 (one word ahead)
    do_reset();
    cyc(1'b0, 2'b11, 2'b00, 8'h01, 8'h81, 8'h00, 8'h00);
    cyc(1'b0, 2'b11, 2'b00, 8'h02, 8'h82, 8'h00, 8'h00);
    cyc(1'b1, 2'b11, 2'b11, 8'hC0, 8'hC1, 8'h01, 8'h81);
    cyc(1'b0, 2'b00, 2'b11, 8'h00, 8'h00, 8'h02, 8'h82);
    check("dual_done_none", {30'd0, done}, 32'd0);
    cyc(1'b0, 2'b00, 2'b01, 8'h00, 8'h00, 8'hC0, 8'h00);
    check("dual_done_ch0", {30'd0, done}, 32'd1);
    cyc(1'b0, 2'b00, 2'b10, 8'h00, 8'h00, 8'h00, 8'hC1);
    check("dual_done_both", {30'd0, done}, 32'd3);
    check("dual_fail", {30'd0, chan_fail}, 32'd0);

    // Reset mid-TRACK discards the old tag
    do_reset();
    cyc(1'b0, 2'b01, 2'b00, 8'h07, 8'h00, 8'h00, 8'h00);
    cyc(1'b1, 2'b01, 2'b00, 8'h99, 8'h00, 8'h00, 8'h00);
    rst = 1'b1;
    cyc(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    rst = 1'b0;
    cyc(1'b1, 2'b01, 2'b00, 8'h3C, 8'h00, 8'h00, 8'h00);
    check("rtrk_done_early", {30'd0, done}, 32'd0);
    cyc(1'b0, 2'b00, 2'b01, 8'h00, 8'h00, 8'h3C, 8'h00);
    check("rtrk_done", {30'd0, done}, 32'd1);
    check("rtrk_fail", {30'd0, chan_fail}, 32'd0);
    check("rtrk_prop", {31'd0, prop_signal}, 32'd1);
`ifdef SB_LATENCY_EN
    check("rtrk_maxlat", {16'd0, max_latency}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
